// File: rtl/cpu_run_controller_pkg.sv
// Shared types and default signatures for the CPU run controller.
package cpu_tb_pkg;

  typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DONE} run_state_t;

  typedef enum logic [2:0] {V_NONE, V_PASS, V_FAIL, V_STALL, V_TIMEOUT} verdict_t;

  localparam logic [31:0] DEF_PASS_VALUE = 32'h600D;
  localparam logic [31:0] DEF_FAIL_VALUE = 32'hBAD0;

endpackage

// File: rtl/cpu_run_controller_stall_detector.sv
// Flags a stall when the monitored bus stays unchanged for STALL_CYCLES consecutive samples.
module stall_detector #(
  parameter int DATA_WIDTH   = 32,
  parameter int STALL_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  stalled_o
);

  localparam bit ENABLED = (STALL_CYCLES > 0);
  localparam int SW      = (STALL_CYCLES < 2) ? 1 : $clog2(STALL_CYCLES);
  localparam int LIM     = (STALL_CYCLES < 1) ? 0 : STALL_CYCLES - 1;
  localparam logic [SW-1:0] LIM_W = SW'(LIM);

  logic [DATA_WIDTH-1:0] prev_q;
  logic                  seeded_q;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic                  same;

  assign same = (data_i == prev_q);

  // The first enabled sample only seeds prev_q, so it can never count as unchanged.
  assign stalled_o = ENABLED && en_i && seeded_q && same && (cnt_q >= LIM_W);

  always_comb begin
    cnt_d = '0;
    if (seeded_q && same) begin
      cnt_d = (cnt_q < LIM_W) ? cnt_q + 1'b1 : cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seeded_q <= 1'b0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      seeded_q <= 1'b0;
      cnt_q    <= '0;
    end else if (en_i) begin
      seeded_q <= 1'b1;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) prev_q <= data_i;
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller: timed CPU reset, cycle counting and latched pass/fail/stall/timeout verdict.
module cpu_run_controller
  import cpu_tb_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    RESET_CYCLES = 5,
  parameter int                    MAX_CYCLES   = 50,
  parameter int                    STALL_CYCLES = 8,
  parameter logic [DATA_WIDTH-1:0] PASS_VALUE   = DATA_WIDTH'(DEF_PASS_VALUE),
  parameter logic [DATA_WIDTH-1:0] FAIL_VALUE   = DATA_WIDTH'(DEF_FAIL_VALUE),
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cpu_out,
  output logic                  cpu_reset,
  output logic                  running,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic                  stall,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [DATA_WIDTH-1:0] last_out
);

  localparam int HW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

  run_state_t            state_q, state_d;
  verdict_t              verdict_q, verdict_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  cpu_reset_q, running_q, done_q;
  logic                  pass_q, fail_q, stall_q, timeout_q;
  logic                  stalled;

  stall_detector #(
    .DATA_WIDTH  (DATA_WIDTH),
    .STALL_CYCLES(STALL_CYCLES)
  ) u_stall (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clear_i  (state_q != RUN),
    .en_i     (state_q == RUN),
    .data_i   (cpu_out),
    .stalled_o(stalled)
  );

  always_comb begin
    state_d   = state_q;
    verdict_d = verdict_q;
    hold_d    = hold_q;
    count_d   = count_q;
    last_d    = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RESET_HOLD;
          hold_d  = '0;
        end
      end
      RESET_HOLD: begin
        count_d = '0;
        if (hold_q == HOLD_LAST) state_d = RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      RUN: begin
        count_d = (count_q == '1) ? count_q : count_q + 1'b1;
        if (cpu_out == FAIL_VALUE)      verdict_d = V_FAIL;
        else if (cpu_out == PASS_VALUE) verdict_d = V_PASS;
        else if (stalled)               verdict_d = V_STALL;
        else if (count_q == CNT_LAST)   verdict_d = V_TIMEOUT;
        if (verdict_d != V_NONE) begin
          state_d = DONE;
          last_d  = cpu_out;
        end
      end
      DONE: begin
        if (start) begin
          state_d   = RESET_HOLD;
          hold_d    = '0;
          verdict_d = V_NONE;
          last_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flags are registered from next-state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      verdict_q   <= V_NONE;
      hold_q      <= '0;
      count_q     <= '0;
      last_q      <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      stall_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      verdict_q   <= verdict_d;
      hold_q      <= hold_d;
      count_q     <= count_d;
      last_q      <= last_d;
      cpu_reset_q <= (state_d != RUN);
      running_q   <= (state_d == RUN);
      done_q      <= (state_d == DONE);
      pass_q      <= (verdict_d == V_PASS);
      fail_q      <= (verdict_d == V_FAIL);
      stall_q     <= (verdict_d == V_STALL);
      timeout_q   <= (verdict_d == V_TIMEOUT);
    end
  end

  // The CPU sees reset the instant our own reset drops, without waiting for a clock edge.
  assign cpu_reset   = cpu_reset_q | ~reset;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign stall       = stall_q;
  assign cycle_count = count_q;
  assign last_out    = last_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller, including a PASS==FAIL override instance.
module tb_cpu_run_controller;

  logic        clock;
  logic        reset;
  logic        start;
  logic        start2;
  logic [31:0] cpu_out;

  logic        cpu_reset, running, done, pass, fail, timeout, stall;
  logic [15:0] cycle_count;
  logic [31:0] last_out;

  logic        cpu_reset2, running2, done2, pass2, fail2, timeout2, stall2;
  logic [15:0] cycle_count2;
  logic [31:0] last_out2;

  int n_checks = 0;
  int n_pass   = 0;
  int hold_n;

  cpu_run_controller u_dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .cpu_out    (cpu_out),
    .cpu_reset  (cpu_reset),
    .running    (running),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .stall      (stall),
    .cycle_count(cycle_count),
    .last_out   (last_out)
  );

  cpu_run_controller #(
    .PASS_VALUE(32'hBAD0),
    .FAIL_VALUE(32'hBAD0)
  ) u_dut_eq (
    .clock      (clock),
    .reset      (reset),
    .start      (start2),
    .cpu_out    (cpu_out),
    .cpu_reset  (cpu_reset2),
    .running    (running2),
    .done       (done2),
    .pass       (pass2),
    .fail       (fail2),
    .timeout    (timeout2),
    .stall      (stall2),
    .cycle_count(cycle_count2),
    .last_out   (last_out2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic also2);
    start  = 1'b1;
    start2 = also2;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_hold(input logic hold_start, output int n);
    n = 0;
    while (cpu_reset && n < 20) begin
      n++;
      start = hold_start;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic run_cycle(input logic [31:0] v);
    cpu_out = v;
    tick();
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    cpu_out = 32'h0;

    // 1: reset held, then released with no start
    repeat (10) tick();
    check_eq("t1_rst_cpu_reset", cpu_reset, 1'b1);
    check_eq("t1_rst_done", done, 1'b0);
    reset = 1'b1;
    repeat (3) tick();
    check_eq("t1_idle_cpu_reset", cpu_reset, 1'b1);
    check_eq("t1_idle_running", running, 1'b0);
    check_eq("t1_idle_flags", {done, pass, fail, timeout, stall}, 5'b0);
    check_eq("t1_idle_count", cycle_count, 16'd0);
    check_eq("t1_idle_last", last_out, 32'h0);
    check_eq("t1_eq_idle", {cpu_reset2, done2}, 2'b10);

    // 2: ramp then PASS at RUN cycle 12
    do_start(1'b0);
    wait_hold(1'b0, hold_n);
    check_eq("t2_hold_cycles", hold_n, 5);
    check_eq("t2_running", running, 1'b1);
    for (int k = 1; k <= 11; k++) run_cycle(32'(k));
    check_eq("t2_count11", cycle_count, 16'd11);
    check_eq("t2_still_running", {running, done}, 2'b10);
    run_cycle(32'h600D);
    check_eq("t2_pass_flags", {done, pass, fail, timeout, stall}, 5'b11000);
    check_eq("t2_count", cycle_count, 16'd12);
    check_eq("t2_last_out", last_out, 32'h600D);
    check_eq("t2_cpu_reset_done", {cpu_reset, running}, 2'b10);
    tick();
    check_eq("t2_count_frozen", cycle_count, 16'd12);

    // 3: FAIL with PASS==FAIL override instance running alongside
    do_start(1'b1);
    wait_hold(1'b0, hold_n);
    check_eq("t3_hold_cycles", hold_n, 5);
    for (int k = 1; k <= 3; k++) run_cycle(32'(k));
    run_cycle(32'hBAD0);
    check_eq("t3_fail_flags", {done, pass, fail, timeout, stall}, 5'b10100);
    check_eq("t3_count", cycle_count, 16'd4);
    check_eq("t3_last", last_out, 32'hBAD0);
    check_eq("t3_eq_flags", {done2, pass2, fail2, timeout2, stall2}, 5'b10100);
    check_eq("t3_eq_ctl", {cpu_reset2, running2}, 2'b10);
    check_eq("t3_eq_count", cycle_count2, 16'd4);
    check_eq("t3_eq_last", last_out2, 32'hBAD0);

    // 4: bus frozen from RUN cycle 3
    do_start(1'b0);
    check_eq("t4_flags_cleared", {done, fail}, 2'b00);
    wait_hold(1'b0, hold_n);
    run_cycle(32'h1);
    run_cycle(32'h2);
    for (int k = 3; k <= 10; k++) run_cycle(32'h1234);
    check_eq("t4_no_stall_yet", {running, stall}, 2'b10);
    run_cycle(32'h1234);
    check_eq("t4_stall_flags", {done, pass, fail, timeout, stall}, 5'b10001);
    check_eq("t4_count", cycle_count, 16'd11);
    check_eq("t4_last", last_out, 32'h1234);

    // 5: timeout, then a fresh run ending in pass
    do_start(1'b0);
    wait_hold(1'b0, hold_n);
    for (int k = 1; k <= 49; k++) run_cycle(32'h100 + 32'(k));
    check_eq("t5_before_timeout", {running, timeout}, 2'b10);
    run_cycle(32'h132);
    check_eq("t5_timeout_flags", {done, pass, fail, timeout, stall}, 5'b10010);
    check_eq("t5_count", cycle_count, 16'd50);
    check_eq("t5_last", last_out, 32'h132);
    do_start(1'b0);
    check_eq("t5_restart_clear", {done, timeout, cpu_reset}, 3'b001);
    wait_hold(1'b0, hold_n);
    check_eq("t5_hold_cycles", hold_n, 5);
    run_cycle(32'h1);
    run_cycle(32'h2);
    run_cycle(32'h600D);
    check_eq("t5_rerun_pass", {done, pass, timeout}, 3'b110);
    check_eq("t5_rerun_count", cycle_count, 16'd3);

    // 6: start ignored in hold/run, async reset mid-RUN
    do_start(1'b0);
    wait_hold(1'b1, hold_n);
    check_eq("t6_hold_with_start", hold_n, 5);
    run_cycle(32'h1);
    run_cycle(32'h2);
    start = 1'b1;
    run_cycle(32'h3);
    start = 1'b0;
    check_eq("t6_start_ignored", {running, cpu_reset, done}, 3'b100);
    check_eq("t6_count3", cycle_count, 16'd3);
    run_cycle(32'h4);
    run_cycle(32'h5);
    run_cycle(32'h6);
    check_eq("t6_count6", cycle_count, 16'd6);
    cpu_out = 32'h7;
    #3;
    reset = 1'b0;
    #1;
    check_eq("t6_async_ctl", {cpu_reset, running, done}, 3'b100);
    check_eq("t6_async_count", cycle_count, 16'd0);
    #1;
    reset = 1'b1;
    tick();
    check_eq("t6_after_idle", {cpu_reset, running, done}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
